// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: width helper, default message width,
// LLR saturation limits and the serial-unit state encoding.
package ldpc_pkg;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) ;
    return r;
  endfunction

  localparam int DATA_W = 8;

  // Symmetric limits: the most negative code is never produced, so negation is safe.
  localparam logic signed [DATA_W-1:0] LLR_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] LLR_MIN = -LLR_MAX;

  typedef enum logic {ACCUM = 1'b0, EMIT = 1'b1} ser_state_e;

endpackage

// File: rtl/llr_sat.sv
// Combinational symmetric saturation of a wide signed value to ±(2^(out_w-1)-1).
module llr_sat #(
  parameter int in_w  = 11,
  parameter int out_w = 8
) (
  input  logic signed [in_w-1:0]  din,
  output logic signed [out_w-1:0] dout
);

  localparam logic signed [in_w-1:0] MAXV = {{(in_w-out_w+1){1'b0}}, {(out_w-1){1'b1}}};
  localparam logic signed [in_w-1:0] MINV = -MAXV;

  always_comb begin
    dout = din[out_w-1:0];
    if (din > MAXV)      dout = MAXV[out_w-1:0];
    else if (din < MINV) dout = MINV[out_w-1:0];
  end

endmodule

// File: rtl/vnu_serial.sv
// Serial min-sum variable-node unit: accumulates LLR + DV check messages,
// then emits DV saturated extrinsic messages plus the hard decision.
module vnu_serial import ldpc_pkg::*; #(
  parameter int DV     = 3,
  parameter int data_w = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [data_w-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w-1:0] out_q,
  output logic [((clog2(DV) < 1) ? 1 : clog2(DV))-1:0] out_idx,
  output logic              out_last,
  output logic              hard_dec
);

  localparam int idx_w = (clog2(DV) < 1) ? 1 : clog2(DV);
  localparam int sum_w = data_w + clog2(DV+1) + 1;
  localparam int cnt_w = clog2(DV+1);

  ser_state_e state, state_nxt;

  logic [cnt_w-1:0]             cnt;
  logic [idx_w-1:0]             idx;
  logic signed [sum_w-1:0]      sum;
  logic [DV-1:0][data_w-1:0]    r_buf;

  logic                         in_fire, out_fire, last_beat;
  logic signed [sum_w-1:0]      in_sext, r_sext, diff;
  logic [data_w-1:0]            r_sel;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_beat = (cnt == cnt_w'(DV));
  assign in_sext   = {{(sum_w-data_w){in_data[data_w-1]}}, in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // out_ready only steers the next state, so in_ready never sees it combinationally.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && out_last) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      sum   <= '0;
      r_buf <= '0;
    end else begin
      if (in_fire) begin
        sum <= sum + in_sext;
        // beat 0 is the channel LLR and is only summed
        for (int i = 0; i < DV; i++)
          if (cnt == cnt_w'(i+1)) r_buf[i] <= in_data;
        cnt <= last_beat ? '0 : cnt + cnt_w'(1);
      end
      if (out_fire) begin
        if (out_last) begin
          idx <= '0;
          sum <= '0;
        end else begin
          idx <= idx + idx_w'(1);
        end
      end
    end
  end

  always_comb begin
    r_sel = '0;
    for (int i = 0; i < DV; i++)
      if (idx == idx_w'(i)) r_sel = r_buf[i];
  end

  assign r_sext = {{(sum_w-data_w){r_sel[data_w-1]}}, r_sel};
  assign diff   = sum - r_sext;

  llr_sat #(.in_w(sum_w), .out_w(data_w)) u_sat (
    .din  (diff),
    .dout (out_q)
  );

  assign out_idx  = idx;
  assign out_last = (idx == idx_w'(DV-1));
  assign hard_dec = sum[sum_w-1];

endmodule

// File: tb/tb_vnu_serial.sv
// Directed self-checking bench for vnu_serial (DV=3, data_w=8).
module tb_vnu_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_q;
  logic [1:0] out_idx;
  logic       out_last, hard_dec;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vnu_serial #(.DV(3), .data_w(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .hard_dec  (hard_dec)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic send(input int v);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'(v);
    chk("in_ready_accum", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic recv(input int q, input int idx, input int hd);
    @(negedge clk);
    out_ready = 1'b1;
    chk("out_valid", int'(out_valid), 1);
    chk("in_ready_emit", int'(in_ready), 0);
    chk("out_q", int'($signed(out_q)), q);
    chk("out_idx", int'(out_idx), idx);
    chk("out_last", int'(out_last), (idx == 2) ? 1 : 0);
    chk("hard_dec", int'(hard_dec), hd);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic frame_in(input int b0, input int b1, input int b2, input int b3);
    send(b0); send(b1); send(b2); send(b3);
  endtask

  task automatic frame_out(input int q0, input int q1, input int q2, input int hd);
    recv(q0, 0, hd); recv(q1, 1, hd); recv(q2, 2, hd);
    @(negedge clk);
    chk("in_ready_after", int'(in_ready), 1);
    chk("out_valid_after", int'(out_valid), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_q", int'(out_q), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_hard_dec", int'(hard_dec), 0);
    rst = 1'b0;

    // nominal: sum 32
    frame_in(10, 5, -3, 20);
    frame_out(27, 35, 12, 0);

    // saturation high and low
    frame_in(127, 127, 127, -1);
    frame_out(127, 127, 127, 0);
    frame_in(-128, -128, -128, 5);
    frame_out(-127, -127, -127, 1);

    // backpressure at idx 1
    frame_in(10, 5, -3, 20);
    recv(27, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_q", int'($signed(out_q)), 35);
      chk("stall_idx", int'(out_idx), 1);
      chk("stall_hd", int'(hard_dec), 0);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    recv(35, 1, 0);
    recv(12, 2, 0);
    @(negedge clk);
    chk("bp_in_ready_after", int'(in_ready), 1);

    // input gaps, then in_valid held through EMIT
    send(10); @(negedge clk);
    send(5);  @(negedge clk);
    send(-3); @(negedge clk);
    send(20);
    in_valid = 1'b1; in_data = 8'd99;
    recv(27, 0, 0); recv(35, 1, 0); recv(12, 2, 0);
    in_valid = 1'b0;
    frame_in(0, 1, 2, 3);
    frame_out(5, 4, 3, 0);

    // reset mid-EMIT at idx 1
    frame_in(10, 5, -3, 20);
    recv(27, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    frame_in(0, 1, 2, 3);
    frame_out(5, 4, 3, 0);

    // zero and boundary
    frame_in(0, 0, 0, 0);
    frame_out(0, 0, 0, 0);
    frame_in(0, 0, 0, -1);
    frame_out(-1, -1, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vnu_serial.md
# vnu_serial

Serial variable-node unit for the min-sum LDPC decoder; it sits directly upstream of the check-node stage. Per variable node it accepts one channel LLR and DV check-to-variable messages, one per beat. It then emits DV saturated extrinsic messages q_i = (LLR + Σr) − r_i, one per beat, together with the hard decision. The q messages are two's-complement, symmetric-saturated, and are what the check-node unit takes its magnitude and sign from.

## Interface
- DV, 3, column degree (number of check messages per variable node), ≥2
- data_w, 8, message width (signed two's complement)
- idx_w, derived = clog2(DV), min 1, width of out_idx
- sum_w, derived = data_w + clog2(DV+1) + 1, accumulator width

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  data_w  beat 0 = channel LLR, beats 1..DV = r messages
- out_valid  out  1  out_q valid
- out_ready  in  1  downstream accepts out_q
- out_q  out  data_w  extrinsic message for edge out_idx
- out_idx  out  idx_w  edge index 0..DV-1
- out_last  out  1  high with the edge DV-1 beat
- hard_dec  out  1  1 when posterior sum < 0; valid while out_valid

## Operation
- FSM with two states: ACCUM and EMIT. Reset puts the FSM in ACCUM, beat counter 0, sum 0, edge index 0.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Each in_valid&in_ready beat adds sign-extended in_data to sum.
  - Beats 1..DV are also stored in r_buf[beat-1]. Beat 0 is only summed.
  - Beat DV accepted → EMIT next cycle; counter clears.
- EMIT:
  - in_ready=0. in_valid is ignored and nothing is consumed.
  - out_valid=1.
  - out_q = sat(sum − sext(r_buf[idx])), where sat clamps to ±(2^(data_w−1)−1). −2^(data_w−1) is never emitted, so the downstream negation is safe.
  - Inputs equal to −2^(data_w−1) are accepted and summed at face value.
  - hard_dec = sum[sum_w-1].
  - On out_valid&out_ready, idx increments.
  - A handshake at idx=DV−1 (out_last=1) returns the FSM to ACCUM, with sum, idx and counter cleared.
- Stall: while out_valid&!out_ready, out_q, out_idx, out_last and hard_dec hold stable.
- Arithmetic: the accumulator never overflows (sum_w covers (DV+1)·2^(data_w−1) plus one subtraction). Saturation is applied only on the output.
- Reset mid-frame (ACCUM or EMIT): all partial state is discarded. The next frame starts at beat 0 with no residue.

## Timing
- Reset values: in_ready=1, out_valid=0, out_q=0, out_idx=0, out_last=0, hard_dec=0.
- Latency: last input beat (beat DV) accepted in cycle t → out_valid=1 in cycle t+1 with idx 0.
- out_q, out_idx, out_last and hard_dec are combinational from registered sum/r_buf/idx only. There is no path from in_* to out_*.
- There is no combinational path from out_ready to in_ready.
- Throughput with no stalls: 2·DV+1 cycles per variable node. Input and output phases do not overlap.
- The last output handshake in cycle u gives in_ready=1 in cycle u+1.
- in_valid gaps are allowed anywhere in ACCUM. out_ready gaps are allowed anywhere in EMIT.

## Structure
- Shared package ldpc_pkg holds:
  - the clog2 function;
  - the default data_w;
  - LLR_MAX/LLR_MIN constants derived from data_w;
  - the state enum {ACCUM, EMIT}, which the future serial CNU wrapper reuses.
- One sub-module: llr_sat, parameterized (in_w, out_w), combinational symmetric saturation from sum_w to data_w. Instantiated once on the output path.
- r_buf is a DV×data_w register array. It is not a RAM.

## Test plan
- Nominal (DV=3, data_w=8): beats 10, 5, −3, 20 → sum 32; out_q = 27, 35, 12 with idx 0, 1, 2; out_last on the third; hard_dec=0; out_valid rises one cycle after the fourth beat.
- Saturation: beats 127, 127, 127, −1 → out_q = 127, 127, 127. Then beats −128, −128, −128, 5 → sum −379; out_q = −127, −127, −127; hard_dec=1. Never −128.
- Backpressure: out_ready low for 3 cycles at idx 1 → out_q, out_idx and hard_dec are unchanged throughout; the frame then completes with the correct values and in_ready=0 until the final handshake.
- Input gaps and ignore: in_valid toggled 1,0,1,0 during ACCUM → the same result as gap-free. in_valid=1 held through EMIT → no beat consumed, and the next frame's first beat is treated as an LLR.
- Reset mid-EMIT at idx 1: out_valid=0 and in_ready=1 immediately. The next frame 0, 1, 2, 3 → sum 6; out_q = 5, 4, 3.
- Zero and boundary: beats 0, 0, 0, 0 → out_q = 0, 0, 0; hard_dec=0. Beats 0, 0, 0, −1 → out_q = −1, −1, 0; hard_dec=1.
